// File: rtl/sad_block_accumulator_pkg.sv
// Shared widths, FSM encoding and pixel helper for the SAD block accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sad_pkg;

  localparam int SAD_W      = 13;
  localparam int PIX_W      = 8;
  localparam int LANES      = 4;
  localparam int LANE_SUM_W = 10;
  localparam int WORD_W     = PIX_W * LANES;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sad_state_t;

  // Unsigned |a - b| of one 8-bit pixel; result always fits in 8 bits.
  function automatic logic [PIX_W-1:0] pix_absdiff(input logic [PIX_W-1:0] a,
                                                   input logic [PIX_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/sad_block_accumulator_if.sv
// Word stream in / SAD results out between the memory read side and the accumulator.
// Latency: n/a (wiring only).
// Backpressure: in_ready qualifies in_valid; a word moves on in_valid & in_ready.
interface sad_block_accumulator_if;
  import sad_pkg::*;

  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] frame_word;
  logic [WORD_W-1:0] window_word_A;
  logic [WORD_W-1:0] window_word_B;
  logic [SAD_W-1:0]  SAD_value_small_A;
  logic [SAD_W-1:0]  SAD_value_small_B;
  logic              sad_done;
  logic              busy;

  // Producer / control side
  modport master (
    output start, in_valid, frame_word, window_word_A, window_word_B,
    input  in_ready, SAD_value_small_A, SAD_value_small_B, sad_done, busy
  );

  // Accumulator side
  modport slave (
    input  start, in_valid, frame_word, window_word_A, window_word_B,
    output in_ready, SAD_value_small_A, SAD_value_small_B, sad_done, busy
  );

endinterface

// File: rtl/sad_block_accumulator_absdiff4.sv
// Four-lane absolute difference of two packed pixel words, summed to 10 bits.
// Latency: combinational.
// Backpressure: none.
module sad_absdiff4
  import sad_pkg::*;
(
  input  logic [WORD_W-1:0]     frame_i,
  input  logic [WORD_W-1:0]     window_i,
  output logic [LANE_SUM_W-1:0] sum_o
);

  // Per-lane |frame - window| summed; 4 x 255 = 1020 fits in 10 bits
  always_comb begin
    sum_o = '0;
    for (int l = 0; l < LANES; l++) begin
      sum_o = sum_o + LANE_SUM_W'(pix_absdiff(frame_i[l*PIX_W +: PIX_W],
                                              window_i[l*PIX_W +: PIX_W]));
    end
  end

endmodule

// File: rtl/sad_block_accumulator.sv
// Accumulates per-byte SAD of a frame word against two candidate windows over one block.
// Latency: word at edge k reaches the accumulators at k+1; last word at k -> sad_done after k+2.
// Backpressure: in_ready only in ACCUM until the block is full; SAD_SATURATE_EN clamps at 8191.
module sad_block_accumulator
  import sad_pkg::*;
#(
  // Words per block, legal range 1..255 (counter is 8 bits and never wraps)
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic                    Clk,
  input  logic                    Reset,
  sad_block_accumulator_if.slave  bus
);

  localparam logic [CNT_W-1:0] WPB_C    = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0] WPB_LAST = CNT_W'(WORDS_PER_BLOCK - 1);

  sad_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   s1_vld_q, s1_vld_d;
  logic [LANE_SUM_W-1:0]  s1_sum_a_q, s1_sum_a_d;
  logic [LANE_SUM_W-1:0]  s1_sum_b_q, s1_sum_b_d;
  logic [SAD_W-1:0]       acc_a_q, acc_a_d;
  logic [SAD_W-1:0]       acc_b_q, acc_b_d;

  logic [LANE_SUM_W-1:0]  lane_sum_a;
  logic [LANE_SUM_W-1:0]  lane_sum_b;
  logic                   accept;

  // Accumulator add; the saturating build clamps at the 13-bit maximum
  function automatic logic [SAD_W-1:0] acc_add(input logic [SAD_W-1:0]      acc,
                                               input logic [LANE_SUM_W-1:0] inc);
`ifdef SAD_SATURATE_EN
    logic [SAD_W:0] full;
    full = {1'b0, acc} + (SAD_W+1)'(inc);
    return full[SAD_W] ? {SAD_W{1'b1}} : full[SAD_W-1:0];
`else
    return acc + SAD_W'(inc);
`endif
  endfunction

  sad_absdiff4 u_absdiff_a (
    .frame_i  (bus.frame_word),
    .window_i (bus.window_word_A),
    .sum_o    (lane_sum_a)
  );

  sad_absdiff4 u_absdiff_b (
    .frame_i  (bus.frame_word),
    .window_i (bus.window_word_B),
    .sum_o    (lane_sum_b)
  );

  // start wins over a same-cycle word, so that word is never consumed
  assign accept = (state_q == ST_ACCUM) && (cnt_q < WPB_C) && bus.in_valid && !bus.start;

  // FSM state register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; DRAIN holds until stage 1 is empty, i.e. the last add has landed
  always_comb begin
    state_d = state_q;
    if (bus.start) begin
      state_d = ST_ACCUM;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_ACCUM: if (accept && (cnt_q == WPB_LAST)) state_d = ST_DRAIN;
        ST_DRAIN: if (!s1_vld_q) state_d = ST_DONE;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    bus.in_ready = (state_q == ST_ACCUM) && (cnt_q < WPB_C);
    bus.busy     = (state_q != ST_IDLE);
    bus.sad_done = (state_q == ST_DONE);
  end

  // Datapath next state: stage-1 capture on accept, stage-2 add when stage 1 is valid
  always_comb begin
    cnt_d      = cnt_q;
    s1_vld_d   = accept;
    s1_sum_a_d = s1_sum_a_q;
    s1_sum_b_d = s1_sum_b_q;
    acc_a_d    = acc_a_q;
    acc_b_d    = acc_b_q;
    if (bus.start) begin
      cnt_d    = '0;
      s1_vld_d = 1'b0;
      acc_a_d  = '0;
      acc_b_d  = '0;
    end else begin
      if (accept) begin
        cnt_d      = cnt_q + 1'b1;
        s1_sum_a_d = lane_sum_a;
        s1_sum_b_d = lane_sum_b;
      end
      if (s1_vld_q) begin
        acc_a_d = acc_add(acc_a_q, s1_sum_a_q);
        acc_b_d = acc_add(acc_b_q, s1_sum_b_q);
      end
    end
  end

  // Datapath registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q      <= '0;
      s1_vld_q   <= 1'b0;
      s1_sum_a_q <= '0;
      s1_sum_b_q <= '0;
      acc_a_q    <= '0;
      acc_b_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      s1_vld_q   <= s1_vld_d;
      s1_sum_a_q <= s1_sum_a_d;
      s1_sum_b_q <= s1_sum_b_d;
      acc_a_q    <= acc_a_d;
      acc_b_q    <= acc_b_d;
    end
  end

  // Results come straight from the accumulators and hold through IDLE
  assign bus.SAD_value_small_A = acc_a_q;
  assign bus.SAD_value_small_B = acc_b_q;

endmodule

// File: tb/tb_sad_block_accumulator.sv
module tb_sad_block_accumulator;
  import sad_pkg::*;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  sad_block_accumulator_if bus8 ();
  sad_block_accumulator_if bus9 ();

  sad_block_accumulator #(.WORDS_PER_BLOCK(8)) u_dut8 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus8)
  );

  sad_block_accumulator #(.WORDS_PER_BLOCK(9)) u_dut9 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus9)
  );

`ifdef SAD_SATURATE_EN
  localparam logic [12:0] OVF_EXP = 13'd8191;
`else
  localparam logic [12:0] OVF_EXP = 13'd988;
`endif

  localparam logic [31:0] BASIC_F = 32'h10203040;

  int checks   = 0;
  int failures = 0;

  // Expected {A, B} per sad_done pulse
  logic [25:0] exp8_q[$];
  logic [25:0] exp9_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic start8();
    bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
  endtask

  task automatic words8(input logic [31:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      bus8.in_valid      = 1'b1;
      bus8.frame_word    = f;
      bus8.window_word_A = a;
      bus8.window_word_B = b;
      step();
    end
    bus8.in_valid = 1'b0;
  endtask

  // Scoreboard monitor for the 8-word instance
  always @(negedge Clk) begin : mon8
    logic [25:0] e;
    if (bus8.sad_done === 1'b1) begin
      if (exp8_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done8_unexpected actual=A%0d/B%0d required=no_sad_done",
                 bus8.SAD_value_small_A, bus8.SAD_value_small_B);
      end else begin
        e = exp8_q.pop_front();
        chk("done8_A", 32'(bus8.SAD_value_small_A), 32'(e[25:13]));
        chk("done8_B", 32'(bus8.SAD_value_small_B), 32'(e[12:0]));
      end
    end
  end

  // Scoreboard monitor for the 9-word instance
  always @(negedge Clk) begin : mon9
    logic [25:0] e;
    if (bus9.sad_done === 1'b1) begin
      if (exp9_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done9_unexpected actual=A%0d/B%0d required=no_sad_done",
                 bus9.SAD_value_small_A, bus9.SAD_value_small_B);
      end else begin
        e = exp9_q.pop_front();
        chk("done9_A", 32'(bus9.SAD_value_small_A), 32'(e[25:13]));
        chk("done9_B", 32'(bus9.SAD_value_small_B), 32'(e[12:0]));
      end
    end
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset              = 1'b0;
    bus8.start         = 1'b0;
    bus8.in_valid      = 1'b0;
    bus8.frame_word    = '0;
    bus8.window_word_A = '0;
    bus8.window_word_B = '0;
    bus9.start         = 1'b0;
    bus9.in_valid      = 1'b0;
    bus9.frame_word    = '0;
    bus9.window_word_A = '0;
    bus9.window_word_B = '0;

    // Reset state
    #12;
    chk("rst_A",        32'(bus8.SAD_value_small_A), 0);
    chk("rst_B",        32'(bus8.SAD_value_small_B), 0);
    chk("rst_sad_done", 32'(bus8.sad_done), 0);
    chk("rst_busy",     32'(bus8.busy), 0);
    chk("rst_in_ready", 32'(bus8.in_ready), 0);
    step();
    Reset = 1'b1;
    step();

    // Basic block, with latency and hold checks
    start8();
    chk("start_busy",     32'(bus8.busy), 1);
    chk("start_in_ready", 32'(bus8.in_ready), 1);
    exp8_q.push_back({13'd0, 13'd1280});
    words8(BASIC_F, BASIC_F, 32'h0, 7);
    words8(BASIC_F, BASIC_F, 32'h0, 1);
    chk("lat_k0_done", 32'(bus8.sad_done), 0);
    step();
    chk("lat_k1_done", 32'(bus8.sad_done), 0);
    step();
    chk("lat_k2_done", 32'(bus8.sad_done), 1);
    step();
    chk("after_done",  32'(bus8.sad_done), 0);
    chk("after_busy",  32'(bus8.busy), 0);
    repeat (3) step();
    chk("hold_A", 32'(bus8.SAD_value_small_A), 0);
    chk("hold_B", 32'(bus8.SAD_value_small_B), 1280);

    // Maximum per lane
    start8();
    exp8_q.push_back({13'd8160, 13'd8160});
    words8(32'hFFFFFFFF, 32'h0, 32'h0, 8);
    repeat (5) step();

    // Gapped in_valid, then overrun after the final transfer
    start8();
    exp8_q.push_back({13'd32, 13'd32});
    bus8.frame_word    = 32'h01010101;
    bus8.window_word_A = 32'h0;
    bus8.window_word_B = 32'h0;
    for (int i = 0; i < 8; i++) begin
      bus8.in_valid = 1'b1;
      step();
      if (i < 7) begin
        bus8.in_valid = 1'b0;
        step();
      end
    end
    for (int j = 0; j < 3; j++) begin
      chk("overrun_in_ready", 32'(bus8.in_ready), 0);
      step();
    end
    bus8.in_valid = 1'b0;
    repeat (3) step();
    chk("overrun_A", 32'(bus8.SAD_value_small_A), 32);
    chk("overrun_B", 32'(bus8.SAD_value_small_B), 32);

    // Abort mid-ACCUM, then a fresh block
    start8();
    words8(BASIC_F, BASIC_F, 32'h0, 4);
    start8();
    chk("abort_clear_B", 32'(bus8.SAD_value_small_B), 0);
    exp8_q.push_back({13'd0, 13'd1280});
    words8(BASIC_F, BASIC_F, 32'h0, 8);
    repeat (5) step();

    // Abort during DRAIN discards the pending result
    start8();
    words8(32'hFFFFFFFF, 32'h0, 32'h0, 8);
    start8();
    chk("drain_abort_A", 32'(bus8.SAD_value_small_A), 0);
    chk("drain_abort_B", 32'(bus8.SAD_value_small_B), 0);
    exp8_q.push_back({13'd0, 13'd1280});
    words8(BASIC_F, BASIC_F, 32'h0, 8);
    repeat (5) step();

    // Reset mid-block
    start8();
    words8(BASIC_F, BASIC_F, 32'h0, 5);
    chk("pre_reset_B", 32'(bus8.SAD_value_small_B), 640);
    Reset = 1'b0;
    #1;
    chk("mid_reset_B",        32'(bus8.SAD_value_small_B), 0);
    chk("mid_reset_busy",     32'(bus8.busy), 0);
    chk("mid_reset_in_ready", 32'(bus8.in_ready), 0);
    step();
    step();
    Reset = 1'b1;
    repeat (6) step();

    // Overflow on the 9-word instance
    bus9.start = 1'b1;
    step();
    bus9.start = 1'b0;
    exp9_q.push_back({OVF_EXP, OVF_EXP});
    for (int i = 0; i < 9; i++) begin
      bus9.in_valid      = 1'b1;
      bus9.frame_word    = 32'hFFFFFFFF;
      bus9.window_word_A = 32'h0;
      bus9.window_word_B = 32'h0;
      step();
    end
    bus9.in_valid = 1'b0;
    repeat (5) step();

    // Every expected sad_done must have been seen
    chk("pending8", 32'(exp8_q.size()), 0);
    chk("pending9", 32'(exp9_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
